// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch stage. Owns the PC, issues one outstanding
// instruction-SRAM read at a time over a req/addr_ok/data_ok handshake, and
// hands {ce, pc} plus the fetched word to ID. Branch redirects from ID keep
// exactly one delay slot (the instruction already requested or in flight).
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  stall,
    input  logic [32:0] br_bus,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic [32:0] if_to_id_bus,
    output logic [31:0] if_inst
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic STOP = 1'b1;

    logic [1:0]  state_q,       state_d;
    logic        started_q,     started_d;
    logic [31:0] fetch_pc_q,    fetch_pc_d;
    logic [31:0] req_pc_q,      req_pc_d;
    logic        redirect_v_q,  redirect_v_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        buf_v_q,       buf_v_d;
    logic [31:0] buf_inst_q,    buf_inst_d;
    logic [32:0] bus_q,         bus_d;
    logic [31:0] inst_q,        inst_d;

    logic        br_e;
    logic [31:0] br_addr;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        accept;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic        take_redirect;

    // Request outputs: quiet during reset and until the first posedge after release.
    always_comb begin
        inst_sram_req  = started_q && (state_q == S_REQ) && (stall[0] != STOP);
        inst_sram_addr = started_q ? fetch_pc_q : '0;
    end

    // Next-state logic for the fetch FSM, PC tracking, redirect and ID output register.
    always_comb begin
        br_e     = br_bus[32];
        br_addr  = br_bus[31:0] & 32'hFFFF_FFFC;
        redir_v  = br_e | redirect_v_q;
        redir_pc = br_e ? br_addr : redirect_pc_q;
        accept   = inst_sram_req && inst_sram_addr_ok;

        state_d       = state_q;
        started_d     = 1'b1;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        redirect_v_d  = redir_v;
        redirect_pc_d = redir_pc;
        buf_v_d       = buf_v_q;
        buf_inst_d    = buf_inst_q;
        bus_d         = bus_q;
        inst_d        = inst_q;
        deliver       = 1'b0;
        deliver_inst  = '0;
        take_redirect = 1'b0;

        case (state_q)
            S_REQ: begin
                // The accepted address is the delay slot; a redirect pending or
                // arriving now steers the following fetch.
                if (accept) begin
                    req_pc_d     = fetch_pc_q;
                    fetch_pc_d   = redir_v ? redir_pc : fetch_pc_q + PC_STEP;
                    redirect_v_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (stall[1] != STOP) begin
                        deliver       = 1'b1;
                        deliver_inst  = inst_sram_rdata;
                        take_redirect = 1'b1;
                        state_d       = S_REQ;
                    end else begin
                        buf_v_d    = 1'b1;
                        buf_inst_d = inst_sram_rdata;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (buf_v_q && (stall[1] != STOP)) begin
                    deliver       = 1'b1;
                    deliver_inst  = buf_inst_q;
                    buf_v_d       = 1'b0;
                    take_redirect = 1'b1;
                    state_d       = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // fetch_pc already advanced past the in-flight delay slot, so a branch
        // seen while waiting simply replaces it before the next request.
        if (take_redirect && redir_v) begin
            fetch_pc_d   = redir_pc;
            redirect_v_d = 1'b0;
        end

        if (deliver) begin
            bus_d  = {1'b1, req_pc_q};
            inst_d = deliver_inst;
        end else if (stall[1] != STOP) begin
            bus_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_REQ;
            started_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
            buf_v_q       <= 1'b0;
            buf_inst_q    <= '0;
            bus_q         <= '0;
            inst_q        <= '0;
        end else begin
            state_q       <= state_d;
            started_q     <= started_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            redirect_v_q  <= redirect_v_d;
            redirect_pc_q <= redirect_pc_d;
            buf_v_q       <= buf_v_d;
            buf_inst_q    <= buf_inst_d;
            bus_q         <= bus_d;
            inst_q        <= inst_d;
        end
    end

    assign if_to_id_bus = bus_q;
    assign if_inst      = inst_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: a bench-side SRAM responder inside each
// transaction task, and a scoreboard queue of expected ID deliveries.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  stall;
    logic [32:0] br_bus;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;

    logic [64:0] exp_q[$];
    int          ce_cycles[$];

    if_fetch_unit #(
        .RESET_PC(32'hBFC0_0000),
        .PC_STEP (32'd4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_bus           (br_bus),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .if_to_id_bus     (if_to_id_bus),
        .if_inst          (if_inst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt = cycle_cnt + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Scoreboard: every ce=1 consumed by ID (stall[1] low) must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && if_to_id_bus[32] === 1'b1 && stall[1] === 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_deliver: got pc=%h inst=%h, required no delivery",
                         if_to_id_bus[31:0], if_inst);
            end else begin
                logic [64:0] e;
                e = exp_q.pop_front();
                if ({if_to_id_bus, if_inst} !== e) begin
                    errors++;
                    $display("FAIL id_deliver: got ce=%0b pc=%h inst=%h, required ce=1 pc=%h inst=%h",
                             if_to_id_bus[32], if_to_id_bus[31:0], if_inst, e[63:32], e[31:0]);
                end
            end
            ce_cycles.push_back(cycle_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        rst = 1'b0;
        stall = '0;
        br_bus = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0;
        exp_q.delete();
        ce_cycles.delete();
        step();
        step();
        if (chk) begin
            @(negedge clk);
            checks++;
            if (if_to_id_bus !== 33'd0) begin errors++; $display("FAIL reset_bus: got %h, required 0", if_to_id_bus); end
            checks++;
            if (if_inst !== 32'd0) begin errors++; $display("FAIL reset_inst: got %h, required 0", if_inst); end
            checks++;
            if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", inst_sram_req); end
            checks++;
            if (inst_sram_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h, required 0", inst_sram_addr); end
        end
        step();
        rst = 1'b1;
        if (chk) begin
            @(negedge clk);
            checks++;
            if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL release_req_early: got %b, required 0", inst_sram_req); end
            @(negedge clk);
            checks++;
            if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL release_req: got %b, required 1", inst_sram_req); end
            checks++;
            if (inst_sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL release_addr: got %h, required bfc00000", inst_sram_addr); end
        end
    endtask

    // mode: 0 plain, 1 branch in REQ before addr_ok, 2 branch with addr_ok,
    // 3 branch during WAIT, 4 two branches during WAIT, 5 stray data_ok in REQ.
    task automatic xact(input logic [31:0] exp_addr, input int unsigned mode,
                        input logic [31:0] t1, input logic [31:0] t2);
        int unsigned n = 0;
        @(negedge clk);
        while (inst_sram_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (inst_sram_req !== 1'b1) begin errors++; $display("FAIL req_timeout: got req=%b after %0d cycles, required 1", inst_sram_req, n); end
        checks++;
        if (inst_sram_addr !== exp_addr) begin errors++; $display("FAIL fetch_addr: got %h, required %h", inst_sram_addr, exp_addr); end
        step();
        if (mode == 1) begin
            br_bus = {1'b1, t1};
            @(negedge clk);
            checks++;
            if (inst_sram_addr !== exp_addr) begin errors++; $display("FAIL delay_slot_addr: got %h, required %h", inst_sram_addr, exp_addr); end
            step();
            br_bus = '0;
        end
        if (mode == 5) begin
            inst_sram_data_ok = 1'b1;
            inst_sram_rdata = 32'hDEAD_BEEF;
            step();
            inst_sram_data_ok = 1'b0;
        end
        inst_sram_addr_ok = 1'b1;
        if (mode == 2) br_bus = {1'b1, t1};
        step();
        inst_sram_addr_ok = 1'b0;
        br_bus = '0;
        if (mode == 3 || mode == 4) begin
            br_bus = {1'b1, t1};
            step();
            br_bus = '0;
        end
        if (mode == 4) begin
            br_bus = {1'b1, t2};
            step();
            br_bus = '0;
        end
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = mem_word(exp_addr);
        exp_q.push_back({1'b1, exp_addr, mem_word(exp_addr)});
        step();
        inst_sram_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1);
    endtask

    task automatic test_sequential();
        do_reset(0);
        for (int i = 0; i < 4; i++) xact(32'hBFC0_0000 + 32'(4 * i), 0, '0, '0);
        step();
        checks++;
        if (ce_cycles.size() != 4) begin
            errors++;
            $display("FAIL seq_count: got %0d deliveries, required 4", ce_cycles.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (ce_cycles[i] - ce_cycles[i-1] != 3) begin
                    errors++;
                    $display("FAIL seq_gap: got %0d cycles, required 3", ce_cycles[i] - ce_cycles[i-1]);
                end
            end
        end
    endtask

    task automatic test_id_stall();
        int unsigned n = 0;
        do_reset(0);
        xact(32'hBFC0_0000, 0, '0, '0);
        @(negedge clk);
        while (inst_sram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (inst_sram_addr !== 32'hBFC0_0004 || inst_sram_req !== 1'b1) begin
            errors++;
            $display("FAIL stall_req: got req=%b addr=%h, required req=1 addr=bfc00004", inst_sram_req, inst_sram_addr);
        end
        step();
        inst_sram_addr_ok = 1'b1;
        step();
        inst_sram_addr_ok = 1'b0;
        stall = 2'b10;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = mem_word(32'hBFC0_0004);
        exp_q.push_back({1'b1, 32'hBFC0_0004, mem_word(32'hBFC0_0004)});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (if_to_id_bus !== 33'd0 || inst_sram_req !== 1'b0) begin
                errors++;
                $display("FAIL hold_frozen: got bus=%h req=%b, required bus=0 req=0", if_to_id_bus, inst_sram_req);
            end
            step();
            inst_sram_data_ok = 1'b0;
        end
        stall = 2'b00;
        step();
        step();
        checks++;
        if (exp_q.size() != 0 || if_to_id_bus[32] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got pending=%0d ce=%b, required pending=0 ce=0", exp_q.size(), if_to_id_bus[32]);
        end
        xact(32'hBFC0_0008, 0, '0, '0);
    endtask

    task automatic test_pc_stall();
        do_reset(0);
        xact(32'hBFC0_0000, 0, '0, '0);
        stall = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (inst_sram_req !== 1'b0) begin errors++; $display("FAIL pc_stall_req: got %b, required 0", inst_sram_req); end
        end
        step();
        stall = 2'b00;
        xact(32'hBFC0_0004, 0, '0, '0);
    endtask

    task automatic test_branch_wait();
        do_reset(0);
        xact(32'hBFC0_0000, 0, '0, '0);
        xact(32'hBFC0_0004, 0, '0, '0);
        xact(32'hBFC0_0008, 3, 32'hBFC0_0100, '0);
        xact(32'hBFC0_0100, 0, '0, '0);
        xact(32'hBFC0_0104, 0, '0, '0);
    endtask

    task automatic test_branch_double();
        do_reset(0);
        xact(32'hBFC0_0000, 4, 32'hBFC0_0100, 32'hBFC0_0200);
        xact(32'hBFC0_0200, 0, '0, '0);
        xact(32'hBFC0_0204, 0, '0, '0);
    endtask

    task automatic test_branch_req();
        do_reset(0);
        xact(32'hBFC0_0000, 1, 32'hBFC0_0300, '0);
        xact(32'hBFC0_0300, 2, 32'hBFC0_0400, '0);
        xact(32'hBFC0_0400, 0, '0, '0);
    endtask

    task automatic test_wrap_align();
        do_reset(0);
        xact(32'hBFC0_0000, 3, 32'hFFFF_FFFC, '0);
        xact(32'hFFFF_FFFC, 0, '0, '0);
        xact(32'h0000_0000, 3, 32'h1000_0103, '0);
        xact(32'h1000_0100, 0, '0, '0);
    endtask

    task automatic test_spurious_data();
        do_reset(0);
        xact(32'hBFC0_0000, 5, '0, '0);
        xact(32'hBFC0_0004, 0, '0, '0);
    endtask

    task automatic test_reset_midflight();
        int unsigned n = 0;
        do_reset(0);
        xact(32'hBFC0_0000, 0, '0, '0);
        @(negedge clk);
        while (inst_sram_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        step();
        inst_sram_addr_ok = 1'b1;
        step();
        inst_sram_addr_ok = 1'b0;
        rst = 1'b0;
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (if_to_id_bus !== 33'd0 || inst_sram_req !== 1'b0 || inst_sram_addr !== 32'd0) begin
            errors++;
            $display("FAIL midflight_reset: got bus=%h req=%b addr=%h, required all 0", if_to_id_bus, inst_sram_req, inst_sram_addr);
        end
        step();
        inst_sram_data_ok = 1'b0;
        step();
        rst = 1'b1;
        xact(32'hBFC0_0000, 0, '0, '0);
        xact(32'hBFC0_0004, 0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_id_stall();
        test_pc_stall();
        test_branch_wait();
        test_branch_double();
        test_branch_req();
        test_wrap_align();
        test_spurious_data();
        test_reset_midflight();
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: got %0d undelivered, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
